bq_decim: RTL
=============

# bq_decim

Decimating output stage placed directly downstream of the biquad filter. It averages each block of 2^LOG2_DECIM consecutive filter output samples into one result and queues the results in a small FIFO. Results leave through a ready/valid port. The block runs entirely in the filter clock domain, which lets a slower consumer (a wishbone reader or a serializer) drain filtered data without dropping samples.

## Interface
Parameters:
- DATAWIDTH, 16, sample width; matches the filter output width.
- LOG2_DECIM, 2, log2 of the decimation ratio; legal range 0..4 (0 = passthrough).
- FIFO_AW, 2, FIFO address width; depth = 2^FIFO_AW entries.

Ports:
- bq_clk_i  in  1  filter clock; the only clock in the block.
- nreset  in  1  asynchronous, active-low reset.
- enable_i  in  1  decimator enable.
- y_i  in  DATAWIDTH  signed filter output sample.
- y_valid_i  in  1  single-cycle strobe; y_i is valid in the same cycle.
- dout_o  in→out  DATAWIDTH  decimated result at the FIFO head (first-word fall-through).
- dout_valid_o  out  1  FIFO is not empty.
- dout_ready_i  in  1  consumer accepts dout_o.
- count_o  out  FIFO_AW+1  FIFO occupancy, 0..2^FIFO_AW.
- overflow_o  out  1  sticky flag; a result was dropped.
- clr_ovf_i  in  1  synchronous clear of overflow_o.

## Operation
- Accumulator width is DATAWIDTH+LOG2_DECIM bits, signed. y_i is sign-extended before it is added.
- Phase counter runs 0..2^LOG2_DECIM-1.
- When enable_i=1 and y_valid_i=1:
  - If phase < last, the block does acc += y and phase += 1.
  - If phase = last, the block forms sum = acc + y, sets result = sum >>> LOG2_DECIM (arithmetic shift), pushes result, then clears acc and phase to 0.
- The result always fits in DATAWIDTH bits. No saturation is needed.
- When enable_i=0, y_valid_i is ignored. acc and phase clear synchronously, so a partial block is discarded. The FIFO continues to drain.
- Push with the FIFO not full: the result is written and count increments.
- Push with the FIFO full and no pop in the same cycle: the result is dropped and overflow_o sets. FIFO contents are unchanged.
- Push with the FIFO full and a pop in the same cycle: the push is accepted and count stays at its maximum.
- Pop occurs when dout_valid_o=1 and dout_ready_i=1. dout_ready_i has no effect when the FIFO is empty.
- Simultaneous push and pop when not full or empty: count is unchanged and order is preserved.
- Read and write pointers are FIFO_AW+1 bits and wrap naturally at depth.
- If clr_ovf_i and an overflow event occur in the same cycle, the set wins.
- When dout_valid_o=0, dout_o holds its last value; after reset it is 0.

## Timing
- Reset (nreset=0) values: acc=0, phase=0, FIFO empty, dout_o=0, dout_valid_o=0, count_o=0, overflow_o=0.
- Reset mid-block discards the partial accumulation and all queued results.
- Latency: the edge that samples the completing y_valid_i writes the FIFO. If the FIFO was empty, dout_valid_o and dout_o are valid in the next cycle.
- Pop takes effect at the sampling edge. The next entry, or dout_valid_o=0, appears in the following cycle.
- count_o and overflow_o are registered and update on the same edge as the push or pop.
- Back-to-back y_valid_i, one strobe per cycle, is supported at full rate.

## Configuration
- BQ_DECIM_ROUND_EN defined: the block adds 2^(LOG2_DECIM-1) to sum before the shift, giving round-half-up. When LOG2_DECIM=0 there is no add.
- BQ_DECIM_ROUND_EN undefined: the shift truncates toward −∞ (floor).
- Max sum plus the rounding term, shifted, still fits in DATAWIDTH bits. Neither mode needs saturation.

## Test plan
- LOG2_DECIM=2, inputs 100, 200, 300, 402 → dout_o=250 (truncate) or 251 (BQ_DECIM_ROUND_EN); dout_valid_o rises one cycle after the 4th strobe.
- Inputs −1, −1, −1, −2 → dout_o=0xFFFE (−2) truncated, or 0xFFFF (−1) rounded.
- 4×32767 then 4×(−32768) → 32767 then −32768 in both modes.
- dout_ready_i=0, push 5 blocks into a depth-4 FIFO → count_o=4, overflow_o=1, and the 5th result is lost. A clr_ovf_i pulse clears the flag. Then hold ready high and confirm the first 4 results drain in order.
- Hold ready=1 with full-rate strobes at LOG2_DECIM=0 → dout_o tracks y_i delayed by one cycle, count_o ≤ 1, and overflow_o never sets.
- Two strobes, then enable_i=0 for 1 cycle, then 4 strobes of 8 → the only output is 8, confirming the partial block was discarded. Repeat with nreset asserted mid-block → all outputs return to reset values.

Source files
------------

// File: rtl/bq_decim_if.sv
// bq_decim_if: ready/valid result stream leaving the decimator.
//   dout_o       - result at the FIFO head (first-word fall-through)
//   dout_valid_o - FIFO not empty
//   dout_ready_i - consumer accepts dout_o
// master = bq_decim (producer), slave = consumer.
interface bq_decim_if #(
    parameter int DATAWIDTH = 16
);
    logic [DATAWIDTH-1:0] dout_o;
    logic                 dout_valid_o;
    logic                 dout_ready_i;

    modport master (output dout_o, output dout_valid_o, input dout_ready_i);
    modport slave  (input dout_o, input dout_valid_o, output dout_ready_i);
endinterface

// File: rtl/bq_decim.sv
// bq_decim: decimating output stage for the biquad filter.
// Averages each block of 2^LOG2_DECIM filter samples into one result and
// queues the results in a small first-word fall-through FIFO that drains
// through a ready/valid interface. Single clock domain (bq_clk_i).
//
// Ports:
//   bq_clk_i   - filter clock
//   nreset     - asynchronous active-low reset
//   enable_i   - decimator enable; low discards any partial block
//   y_i        - signed filter sample, qualified by y_valid_i
//   y_valid_i  - single-cycle sample strobe
//   dout       - bq_decim_if.master result stream (dout_o/dout_valid_o/dout_ready_i)
//   count_o    - FIFO occupancy 0..2^FIFO_AW
//   overflow_o - sticky: a result was dropped on a full FIFO
//   clr_ovf_i  - synchronous clear of overflow_o (a same-cycle overflow wins)
//
// Build option: define BQ_DECIM_ROUND_EN for round-half-up averaging;
// otherwise the average truncates toward minus infinity.
module bq_decim #(
    parameter int DATAWIDTH  = 16,
    parameter int LOG2_DECIM = 2,
    parameter int FIFO_AW    = 2
) (
    input  logic                 bq_clk_i,
    input  logic                 nreset,
    input  logic                 enable_i,
    input  logic [DATAWIDTH-1:0] y_i,
    input  logic                 y_valid_i,
    bq_decim_if.master           dout,
    output logic [FIFO_AW:0]     count_o,
    output logic                 overflow_o,
    input  logic                 clr_ovf_i
);
    localparam int AW    = DATAWIDTH + LOG2_DECIM;
    localparam int PW    = (LOG2_DECIM > 0) ? LOG2_DECIM : 1;
    localparam int CW    = FIFO_AW + 1;
    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [PW-1:0] LAST = PW'((1 << LOG2_DECIM) - 1);

    // ---------------- accumulator ----------------
    logic signed [AW-1:0]        acc;
    logic [PW-1:0]               phase;
    logic signed [DATAWIDTH-1:0] y_s;
    logic signed [AW-1:0]        y_ext;
    logic signed [AW-1:0]        sum;
    logic signed [AW-1:0]        sum_r;
    logic [DATAWIDTH-1:0]        result;
    logic                        push;

    assign y_s   = y_i;
    assign y_ext = AW'(y_s);
    assign sum   = acc + y_ext;

`ifdef BQ_DECIM_ROUND_EN
    // Half an LSB of the output (zero when not decimating); the headroom of
    // the accumulator guarantees this cannot wrap.
    localparam logic signed [AW-1:0] RND = AW'((1 << LOG2_DECIM) >> 1);
    assign sum_r = sum + RND;
`else
    assign sum_r = sum;
`endif

    // Average of a full block always fits back into DATAWIDTH bits.
    assign result = DATAWIDTH'(sum_r >>> LOG2_DECIM);
    assign push   = enable_i && y_valid_i && (phase == LAST);

    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) begin
            acc   <= '0;
            phase <= '0;
        end else if (!enable_i) begin
            acc   <= '0;
            phase <= '0;
        end else if (y_valid_i) begin
            if (phase == LAST) begin
                acc   <= '0;
                phase <= '0;
            end else begin
                acc   <= sum;
                phase <= phase + PW'(1);
            end
        end
    end

    // ---------------- result FIFO ----------------
    logic [DATAWIDTH-1:0] mem [DEPTH];
    logic [FIFO_AW:0]     wptr;
    logic [FIFO_AW:0]     rptr;
    logic [DATAWIDTH-1:0] head;
    logic [DATAWIDTH-1:0] last_q;
    logic                 full;
    logic                 pop;
    logic                 wr_en;
    logic                 ovf_evt;

    assign full    = (count_o == CW'(DEPTH));
    assign pop     = dout.dout_valid_o && dout.dout_ready_i;
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign wr_en   = push && (!full || pop);
    assign ovf_evt = push && full && !pop;
    assign head    = mem[rptr[FIFO_AW-1:0]];

    assign dout.dout_valid_o = (count_o != '0);
    // When empty, keep presenting the last result that left (0 after reset).
    assign dout.dout_o       = dout.dout_valid_o ? head : last_q;

    always_ff @(posedge bq_clk_i) begin
        if (wr_en) mem[wptr[FIFO_AW-1:0]] <= result;
    end

    always_ff @(posedge bq_clk_i or negedge nreset) begin
        if (!nreset) begin
            wptr       <= '0;
            rptr       <= '0;
            count_o    <= '0;
            last_q     <= '0;
            overflow_o <= 1'b0;
        end else begin
            if (wr_en) wptr <= wptr + CW'(1);
            if (pop) begin
                rptr   <= rptr + CW'(1);
                last_q <= head;
            end
            count_o <= count_o + CW'(wr_en) - CW'(pop);
            if (ovf_evt)        overflow_o <= 1'b1;
            else if (clr_ovf_i) overflow_o <= 1'b0;
        end
    end
endmodule
